// File: rtl/gpr_decode_ctrl.sv
// -----------------------------------------------------------------------------
// gpr_decode_ctrl
//
// Multi-cycle decode and register-file control stage for a small MIPS subset.
// One instruction is accepted at a time. Its fields are decoded and the
// register-file addresses are held stable across the file's multi-cycle read
// phase. The execute unit is then started and awaited, and the write enable is
// held across the multi-cycle write phase.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   instr_valid  upstream instruction present
//   instr        32-bit instruction word
//   instr_ready  block can accept an instruction (IDLE only)
//   exec_done    execute unit result valid (only looked at in EX)
//   a1, a2, a3   register-file addresses (rs, rt, rd)
//   swp12        operand swap: rd1 returns rt, rd2 returns rs
//   reg_w        write code: 0 none, 2 write rt, 3 write rd
//   imm32        extended immediate
//   shamt        shift amount
//   alu_op       execute-unit operation code
//   exec_start   one-cycle pulse in the last read cycle, just before EX
//   busy         high in every state except IDLE
//   illegal      one-cycle pulse (in DEC) for an undecodable instruction
// -----------------------------------------------------------------------------
module gpr_decode_ctrl #(
  parameter int RD_CYCLES = 6,
  parameter int WB_CYCLES = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        exec_done,
  output logic [4:0]  a1,
  output logic [4:0]  a2,
  output logic [4:0]  a3,
  output logic        swp12,
  output logic [1:0]  reg_w,
  output logic [31:0] imm32,
  output logic [4:0]  shamt,
  output logic [3:0]  alu_op,
  output logic        exec_start,
  output logic        busy,
  output logic        illegal
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DEC  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_EX   = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  // The counter only ever holds (cycles - 1), so clog2 of the larger
  // parameter is enough.
  localparam int CNT_MAX = (RD_CYCLES > WB_CYCLES) ? RD_CYCLES : WB_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WB_LOAD = CW'(WB_CYCLES - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   instr_q;
  logic [1:0]    wcode;

  // Decode of the latched instruction. It is only consumed in DEC.
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic        dec_legal;
  logic        dec_swp;
  logic [3:0]  dec_alu;
  logic [1:0]  dec_code;
  logic [31:0] dec_imm;

  assign op    = instr_q[31:26];
  assign funct = instr_q[5:0];
  assign imm16 = instr_q[15:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statements can leave a latch behind.
    dec_legal = 1'b1;
    dec_swp   = 1'b0;
    dec_alu   = 4'd0;
    dec_code  = 2'd0;
    dec_imm   = {{16{imm16[15]}}, imm16};
    case (op)
      6'h00: begin
        dec_code = 2'd3;
        case (funct)
          6'h21: dec_alu = 4'd0;
          6'h23: dec_alu = 4'd1;
          6'h24: dec_alu = 4'd2;
          6'h25: dec_alu = 4'd3;
          6'h2A: dec_alu = 4'd4;
          6'h00: begin dec_alu = 4'd5; dec_swp = 1'b1; end
          6'h02: begin dec_alu = 4'd6; dec_swp = 1'b1; end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h09: begin dec_alu = 4'd0; dec_code = 2'd2; end
      6'h0A: begin dec_alu = 4'd4; dec_code = 2'd2; end
      6'h0C: begin dec_alu = 4'd2; dec_code = 2'd2; dec_imm = {16'h0, imm16}; end
      6'h0D: begin dec_alu = 4'd3; dec_code = 2'd2; dec_imm = {16'h0, imm16}; end
      6'h0F: begin dec_alu = 4'd7; dec_code = 2'd2; dec_imm = {imm16, 16'h0}; end
      6'h23: begin dec_alu = 4'd0; dec_code = 2'd2; end
      6'h2B: dec_alu = 4'd0;
      6'h04: dec_alu = 4'd1;
      6'h05: dec_alu = 4'd1;
      default: dec_legal = 1'b0;
    endcase
    // The register file does not protect $0, so a write to it is dropped here.
    if ((dec_code == 2'd3 && instr_q[15:11] == 5'd0) ||
        (dec_code == 2'd2 && instr_q[20:16] == 5'd0))
      dec_code = 2'd0;
    if (!dec_legal)
      dec_code = 2'd0;
  end

  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      instr_q <= '0;
      wcode   <= 2'd0;
      reg_w   <= 2'd0;
      a1      <= 5'd0;
      a2      <= 5'd0;
      a3      <= 5'd0;
      shamt   <= 5'd0;
      swp12   <= 1'b0;
      imm32   <= 32'd0;
      alu_op  <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= S_DEC;
          end
        end
        S_DEC: begin
          a1     <= instr_q[25:21];
          a2     <= instr_q[20:16];
          a3     <= instr_q[15:11];
          shamt  <= instr_q[10:6];
          imm32  <= dec_imm;
          alu_op <= dec_alu;
          swp12  <= dec_swp;
          wcode  <= dec_code;
          if (dec_legal) begin
            cnt   <= RD_LOAD;
            state <= S_RD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RD: begin
          if (cnt == '0) state <= S_EX;
          else           cnt   <= cnt - CW'(1);
        end
        S_EX: begin
          if (exec_done) begin
            if (wcode == 2'd0) begin
              state <= S_IDLE;
            end else begin
              cnt   <= WB_LOAD;
              reg_w <= wcode;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (cnt == '0) begin
            reg_w <= 2'd0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // exec_start fires in the final read cycle so EX begins on the next edge,
  // after the addresses have been stable for RD_CYCLES cycles.
  assign exec_start  = (state == S_RD) && (cnt == '0);
  assign illegal     = (state == S_DEC) && !dec_legal;
  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_gpr_decode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpr_decode_ctrl
//
// Self-checking bench for gpr_decode_ctrl. Expected decode results are
// hand-derived constants pushed to a scoreboard queue when an instruction is
// driven, and popped when the DUT pulses exec_start or illegal.
// -----------------------------------------------------------------------------
module tb_gpr_decode_ctrl;

  localparam int RD_CYCLES = 6;
  localparam int WB_CYCLES = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        exec_done;
  logic [4:0]  a1, a2, a3, shamt;
  logic        swp12;
  logic [1:0]  reg_w;
  logic [31:0] imm32;
  logic [3:0]  alu_op;
  logic        exec_start, busy, illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  a1, a2, a3, shamt;
    logic [3:0]  alu;
    logic        swp;
    logic [31:0] imm;
    logic [1:0]  code;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  gpr_decode_ctrl #(.RD_CYCLES(RD_CYCLES), .WB_CYCLES(WB_CYCLES)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .exec_done(exec_done), .a1(a1), .a2(a2),
    .a3(a3), .swp12(swp12), .reg_w(reg_w), .imm32(imm32), .shamt(shamt),
    .alu_op(alu_op), .exec_start(exec_start), .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [4:0] ea1, input logic [4:0] ea2,
                              input logic [4:0] ea3, input logic [4:0] esh,
                              input logic [3:0] ealu, input logic eswp,
                              input logic [31:0] eimm, input logic [1:0] ecode,
                              input logic eill);
    exp_t e;
    e.a1 = ea1; e.a2 = ea2; e.a3 = ea3; e.shamt = esh; e.alu = ealu;
    e.swp = eswp; e.imm = eimm; e.code = ecode; e.ill = eill;
    return e;
  endfunction

  task automatic check_fields(input string nm, input exp_t e);
    total++;
    if ({a1, a2, a3, shamt, alu_op, swp12, imm32} !==
        {e.a1, e.a2, e.a3, e.shamt, e.alu, e.swp, e.imm}) begin
      bad++;
      $display("FAIL %s fields: got a1=%0d a2=%0d a3=%0d sh=%0d alu=%0d swp=%0b imm=%h, want a1=%0d a2=%0d a3=%0d sh=%0d alu=%0d swp=%0b imm=%h",
               nm, a1, a2, a3, shamt, alu_op, swp12, imm32,
               e.a1, e.a2, e.a3, e.shamt, e.alu, e.swp, e.imm);
    end
  endtask

  // Drive one instruction and follow it to completion. done_dly: EX cycles
  // before exec_done. hold_rd: exec_done held high through DEC/RD.
  // keep_valid: instr_valid stays high (with next_ins) while the block is busy.
  task automatic do_txn(input string nm, input logic [31:0] ins, input exp_t e,
                        input int done_dly, input bit hold_rd,
                        input bit keep_valid, input logic [31:0] next_ins);
    int n;
    bit w_early, ready_busy;
    exp_t cur;
    n = 0;
    while (!instr_ready && n < 50) begin tick(); n++; end
    total++;
    if (!instr_ready) begin
      bad++;
      $display("FAIL %s ready_timeout: instr_ready=%0b want 1", nm, instr_ready);
      return;
    end
    sb.push_back(e);
    instr_valid = 1'b1;
    instr       = ins;
    tick();                                   // DEC cycle
    if (keep_valid) instr = next_ins;
    else            instr_valid = 1'b0;
    if (hold_rd) exec_done = 1'b1;
    if (e.ill) begin
      cur = sb.pop_front();
      total++;
      if (illegal !== 1'b1 || reg_w !== 2'd0) begin
        bad++;
        $display("FAIL %s illegal_pulse: illegal=%0b reg_w=%0d want 1/0", nm, illegal, reg_w);
      end
      tick();
      total++;
      if (illegal !== 1'b0 || instr_ready !== 1'b1 || reg_w !== 2'd0) begin
        bad++;
        $display("FAIL %s illegal_after: illegal=%0b ready=%0b reg_w=%0d want 0/1/0",
                 nm, illegal, instr_ready, reg_w);
      end
      return;
    end
    n = 1;
    w_early = 1'b0;
    ready_busy = 1'b0;
    while (!exec_start && n < 30) begin
      if (reg_w !== 2'd0) w_early = 1'b1;
      if (instr_ready !== 1'b0) ready_busy = 1'b1;
      tick();
      n++;
    end
    total++;
    if (n != RD_CYCLES + 1) begin
      bad++;
      $display("FAIL %s exec_start_latency: got %0d cycles want %0d", nm, n, RD_CYCLES + 1);
    end
    total++;
    if (w_early || ready_busy) begin
      bad++;
      $display("FAIL %s pre_ex: early_write=%0b ready_while_busy=%0b want 0/0", nm, w_early, ready_busy);
    end
    cur = sb.pop_front();
    check_fields(nm, cur);
    exec_done = 1'b0;
    tick();                                   // first EX cycle
    if (hold_rd) begin
      total++;
      if (busy !== 1'b1 || reg_w !== 2'd0 || exec_start !== 1'b0) begin
        bad++;
        $display("FAIL %s rd_done_ignored: busy=%0b reg_w=%0d start=%0b want 1/0/0",
                 nm, busy, reg_w, exec_start);
      end
    end
    repeat (done_dly) tick();
    exec_done = 1'b1;
    tick();                                   // E+1
    exec_done = 1'b0;
    n = 0;
    while (reg_w !== 2'd0 && n < 20) begin
      total++;
      if (reg_w !== cur.code) begin
        bad++;
        $display("FAIL %s reg_w_value: got %0d want %0d", nm, reg_w, cur.code);
      end
      if (n == WB_CYCLES - 1) check_fields({nm, "_held"}, cur);
      tick();
      n++;
    end
    total++;
    if (n != ((cur.code != 2'd0) ? WB_CYCLES : 0)) begin
      bad++;
      $display("FAIL %s wb_length: got %0d want %0d", nm, n,
               (cur.code != 2'd0) ? WB_CYCLES : 0);
    end
    total++;
    if (instr_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s return_idle: ready=%0b busy=%0b want 1/0", nm, instr_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; instr = 32'd0; exec_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    total++;
    if ({instr_ready, busy, reg_w, a1, a2, a3, shamt, swp12, imm32, alu_op, exec_start, illegal}
        !== {1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: ready=%0b busy=%0b reg_w=%0d a1=%0d imm=%h alu=%0d want 1/0/0/0/0/0",
               instr_ready, busy, reg_w, a1, imm32, alu_op);
    end
  endtask

  task automatic test_rtype();
    do_txn("addu", 32'h0022_1821, mk(5'd1, 5'd2, 5'd3, 5'd0, 4'd0, 1'b0, 32'h0000_1821, 2'd3, 1'b0),
           2, 1'b0, 1'b0, 32'd0);
    do_txn("sll", 32'h0007_1100, mk(5'd0, 5'd7, 5'd2, 5'd4, 4'd5, 1'b1, 32'h0000_1100, 2'd3, 1'b0),
           0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_itype();
    do_txn("addiu", 32'h2485_FFFF, mk(5'd4, 5'd5, 5'd31, 5'd31, 4'd0, 1'b0, 32'hFFFF_FFFF, 2'd2, 1'b0),
           1, 1'b0, 1'b0, 32'd0);
    do_txn("ori", 32'h3485_FFFF, mk(5'd4, 5'd5, 5'd31, 5'd31, 4'd3, 1'b0, 32'h0000_FFFF, 2'd2, 1'b0),
           3, 1'b0, 1'b0, 32'd0);
    do_txn("lui", 32'h3C06_1234, mk(5'd0, 5'd6, 5'd2, 5'd8, 4'd7, 1'b0, 32'h1234_0000, 2'd2, 1'b0),
           0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_no_write();
    do_txn("beq", 32'h1022_0003, mk(5'd1, 5'd2, 5'd0, 5'd0, 4'd1, 1'b0, 32'h0000_0003, 2'd0, 1'b0),
           1, 1'b0, 1'b0, 32'd0);
    do_txn("addu_r0", 32'h0022_0021, mk(5'd1, 5'd2, 5'd0, 5'd0, 4'd0, 1'b0, 32'h0000_0021, 2'd0, 1'b0),
           0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_illegal();
    exp_t z;
    z = mk(5'd0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 32'd0, 2'd0, 1'b1);
    do_txn("ill_op3f", 32'hFC00_0000, z, 0, 1'b0, 1'b0, 32'd0);
    do_txn("ill_funct", 32'h0022_183F, z, 0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_exec_done_in_rd();
    do_txn("done_in_rd", 32'h0022_1821, mk(5'd1, 5'd2, 5'd3, 5'd0, 4'd0, 1'b0, 32'h0000_1821, 2'd3, 1'b0),
           2, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic test_back_to_back();
    do_txn("b2b_first", 32'h2485_FFFF, mk(5'd4, 5'd5, 5'd31, 5'd31, 4'd0, 1'b0, 32'hFFFF_FFFF, 2'd2, 1'b0),
           1, 1'b0, 1'b1, 32'h0022_1821);
    do_txn("b2b_second", 32'h0022_1821, mk(5'd1, 5'd2, 5'd3, 5'd0, 4'd0, 1'b0, 32'h0000_1821, 2'd3, 1'b0),
           0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_reset_in_wb();
    int n;
    bit wrote;
    n = 0;
    instr_valid = 1'b1;
    instr       = 32'h0022_1821;
    tick();
    instr_valid = 1'b0;
    while (!exec_start && n < 30) begin tick(); n++; end
    tick();
    exec_done = 1'b1;
    tick();                                   // WB cycle 1
    exec_done = 1'b0;
    tick();                                   // WB cycle 2
    tick();                                   // WB cycle 3
    total++;
    if (reg_w !== 2'd3) begin
      bad++;
      $display("FAIL rst_wb_pre: reg_w=%0d want 3", reg_w);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (reg_w !== 2'd0 || busy !== 1'b0 || instr_ready !== 1'b1 || a1 !== 5'd0) begin
      bad++;
      $display("FAIL rst_wb_after: reg_w=%0d busy=%0b ready=%0b a1=%0d want 0/0/1/0",
               reg_w, busy, instr_ready, a1);
    end
    wrote = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (reg_w !== 2'd0 || busy !== 1'b0) wrote = 1'b1;
      tick();
    end
    total++;
    if (wrote) begin
      bad++;
      $display("FAIL rst_wb_quiet: write or activity seen after reset, want none");
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_no_write();
    test_illegal();
    test_exec_done_in_rd();
    test_back_to_back();
    test_reset_in_wb();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
